// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expander.
// Emits rk[0]..rk[Nr] over a valid/ready port using one shared SubWord unit.
module aes_key_schedule #(
    parameter int         SBOX_REG    = 1,
    parameter logic [2:0] KEY_SUPPORT = 3'b111
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    input  logic         abort,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, GEN, SUB, HOLD} state_t;

    state_t        state, state_nx;
    logic [1:0]    klen;
    logic [31:0]   win [8];
    logic [5:0]    i_cnt;
    logic [2:0]    kpos;
    logic [7:0]    rcon;
    logic [31:0]   sub_q;
    logic [127:0]  stg;
    logic [2:0]    stg_cnt;

    logic [2:0]    nk_m1;
    logic [3:0]    nr;
    logic [5:0]    total;
    logic [31:0]   wold;
    logic [31:0]   wprev;
    logic          need_rot;
    logic          need_sub;
    logic [31:0]   sub_in;
    logic [31:0]   sub_comb;
    logic [31:0]   sub_src;
    logic [31:0]   t_word;
    logic [31:0]   w_new;
    logic          more;
    logic          sup;
    logic [5:0]    ld_nk;
    logic          ld, wr, cap, err_nx;
    logic          accept, out_free;
    logic [127:0]  stg_sh;
    logic [3:0]    idx_inc;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // x^254 is the field inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        logic [7:0] e;
        r = 8'h01;
        s = a;
        e = 8'hfe;
        for (int k = 0; k < 8; k++) begin
            if (e[k]) r = gf_mul(r, s);
            s = gf_mul(s, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Per-length constants and the w[i-Nk] tap of the window
    always_comb begin
        nk_m1 = 3'd3;
        nr    = 4'd10;
        total = 6'd44;
        wold  = win[4];
        case (klen)
            2'd1: begin
                nk_m1 = 3'd5;
                nr    = 4'd12;
                total = 6'd52;
                wold  = win[2];
            end
            2'd2: begin
                nk_m1 = 3'd7;
                nr    = 4'd14;
                total = 6'd60;
                wold  = win[0];
            end
            default: ;
        endcase
    end

    // Start-side decode of the requested key length
    always_comb begin
        sup   = 1'b0;
        ld_nk = 6'd4;
        case (key_len)
            2'd0: sup = KEY_SUPPORT[0];
            2'd1: begin
                sup   = KEY_SUPPORT[1];
                ld_nk = 6'd6;
            end
            2'd2: begin
                sup   = KEY_SUPPORT[2];
                ld_nk = 6'd8;
            end
            default: sup = 1'b0;
        endcase
    end

    assign wprev    = win[7];
    assign need_rot = (kpos == 3'd0);
    assign need_sub = need_rot || (klen == 2'd2 && kpos == 3'd4);
    assign sub_in   = need_rot ? {wprev[23:0], wprev[31:24]} : wprev;
    assign sub_comb = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                       sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    assign sub_src  = (SBOX_REG != 0) ? sub_q : sub_comb;
    assign t_word   = need_sub
                    ? (sub_src ^ (need_rot ? {rcon, 24'h0} : 32'h0))
                    : wprev;
    assign w_new    = wold ^ t_word;
    assign more     = (i_cnt < total);
    assign accept   = rk_valid && rk_ready;
    assign out_free = !rk_valid || rk_ready;
    assign stg_sh   = {stg[95:0], w_new};
    assign idx_inc  = rk_index + 4'd1;
    assign busy     = (state != IDLE);

    // Next-state and datapath strobes
    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        wr       = 1'b0;
        cap      = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (sup) begin
                        ld       = 1'b1;
                        state_nx = (key_len == 2'd2) ? HOLD : GEN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            GEN: begin
                if (more) begin
                    if (need_sub && SBOX_REG != 0) begin
                        cap      = 1'b1;
                        state_nx = SUB;
                    end else begin
                        wr = 1'b1;
                    end
                end else if (accept && rk_last) begin
                    state_nx = IDLE;
                end
            end
            SUB: begin
                wr       = 1'b1;
                state_nx = GEN;
            end
            HOLD: begin
                if (rk_ready) state_nx = GEN;
            end
            default: state_nx = IDLE;
        endcase
        if (wr && stg_cnt == 3'd3 && !out_free) state_nx = HOLD;
        if (abort) begin
            state_nx = IDLE;
            ld       = 1'b0;
            wr       = 1'b0;
            cap      = 1'b0;
            err_nx   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Window, counters, staging and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < 8; j++) win[j] <= 32'h0;
            klen     <= 2'd0;
            i_cnt    <= 6'd0;
            kpos     <= 3'd0;
            rcon     <= 8'h00;
            sub_q    <= 32'h0;
            stg      <= 128'h0;
            stg_cnt  <= 3'd0;
            rk_valid <= 1'b0;
            rk_data  <= 128'h0;
            rk_index <= 4'd0;
            rk_last  <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= err_nx;
            if (ld) begin
                klen     <= key_len;
                i_cnt    <= ld_nk;
                kpos     <= 3'd0;
                rcon     <= 8'h01;
                rk_data  <= key_in[255:128];
                rk_index <= 4'd0;
                rk_valid <= 1'b1;
                rk_last  <= 1'b0;
                case (key_len)
                    2'd1: begin
                        for (int j = 0; j < 6; j++)
                            win[j+2] <= key_in[255-32*j -: 32];
                        stg     <= {64'h0, key_in[127:64]};
                        stg_cnt <= 3'd2;
                    end
                    2'd2: begin
                        for (int j = 0; j < 8; j++)
                            win[j] <= key_in[255-32*j -: 32];
                        stg     <= key_in[127:0];
                        stg_cnt <= 3'd4;
                    end
                    default: begin
                        for (int j = 0; j < 4; j++)
                            win[j+4] <= key_in[255-32*j -: 32];
                        stg     <= 128'h0;
                        stg_cnt <= 3'd0;
                    end
                endcase
            end else if (abort) begin
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
            end else begin
                if (cap) sub_q <= sub_comb;
                if (wr) begin
                    for (int j = 0; j < 7; j++) win[j] <= win[j+1];
                    win[7] <= w_new;
                    i_cnt  <= i_cnt + 6'd1;
                    kpos   <= (kpos == nk_m1) ? 3'd0 : kpos + 3'd1;
                    if (need_rot) rcon <= xt(rcon);
                end
                if (wr && stg_cnt == 3'd3 && out_free) begin
                    stg      <= stg_sh;
                    stg_cnt  <= 3'd0;
                    rk_data  <= stg_sh;
                    rk_index <= idx_inc;
                    rk_valid <= 1'b1;
                    rk_last  <= (idx_inc == nr);
                end else if (state == HOLD && rk_ready) begin
                    stg_cnt  <= 3'd0;
                    rk_data  <= stg;
                    rk_index <= idx_inc;
                    rk_valid <= 1'b1;
                    rk_last  <= (idx_inc == nr);
                end else begin
                    if (wr) begin
                        stg     <= stg_sh;
                        stg_cnt <= stg_cnt + 3'd1;
                    end
                    if (accept) begin
                        rk_valid <= 1'b0;
                        rk_last  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 vectors, back-pressure,
// err, abort and asynchronous reset against a textbook expansion model.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic         start1;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         abort;
    logic         rk_ready;
    logic         busy, rk_valid, rk_last, err;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         busy1, rk_valid1, rk_last1, err1;
    logic [127:0] rk_data1;
    logic [3:0]   rk_index1;

    aes_key_schedule #(.SBOX_REG(1), .KEY_SUPPORT(3'b111)) u_dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len),
        .key_in(key_in), .abort(abort), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_index(rk_index), .rk_last(rk_last), .err(err)
    );

    aes_key_schedule #(.SBOX_REG(1), .KEY_SUPPORT(3'b001)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .key_len(key_len),
        .key_in(key_in), .abort(abort), .busy(busy1),
        .rk_valid(rk_valid1), .rk_ready(rk_ready), .rk_data(rk_data1),
        .rk_index(rk_index1), .rk_last(rk_last1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   idx;
        logic         last;
        logic [127:0] data;
    } exp_t;

    exp_t         sbq[$];
    logic [7:0]   sb[256];
    logic [127:0] got[15];
    int           n_chk;
    int           n_fail;
    int           n_xfer;
    int           last_cyc;

    localparam logic [255:0] K128 =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 =
        {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and bitwise affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (tb_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            for (int k = 0; k < 8; k++)
                s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8]
                     ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic push_model(input logic [255:0] key, input int kl);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rc[10];
        int nk;
        int nr;
        exp_t e;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        nk = 4 + 2 * kl;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0)
                t = sub_w({t[23:0], t[31:24]}) ^ {rc[i/nk-1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = sub_w(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            e.idx  = r[3:0];
            e.last = (r == nr);
            e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            sbq.push_back(e);
        end
    endtask

    // Drives one expansion from the current negedge; mode 1 = ~30% ready
    task automatic run_keys(input logic [255:0] key, input int kl,
                            input int mode, input int abort_at,
                            input int poke);
        int   cyc;
        int   nr;
        bit   done;
        bit   prev_stall;
        bit   seen_last;
        logic [132:0] snap;
        exp_t e;
        nr = 10 + 2 * kl;
        sbq.delete();
        push_model(key, kl);
        key_in     = key;
        key_len    = kl[1:0];
        start      = 1'b1;
        rk_ready   = (mode == 0);
        cyc        = 0;
        done       = 0;
        prev_stall = 0;
        seen_last  = 0;
        n_xfer     = 0;
        last_cyc   = -1;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) check("rk0_latency", rk_valid, 1'b1);
            if (prev_stall)
                check("stall_stable", {rk_valid, rk_index, rk_last, rk_data},
                      {1'b1, snap});
            if (poke != 0 && cyc == 10) begin
                start   = 1'b1;
                key_len = 2'd0;
                key_in  = ~key;
            end
            if (poke != 0 && cyc == 11) check("busy_start_no_err", err, 1'b0);
            if (rk_valid && rk_last && !seen_last) begin
                seen_last = 1;
                last_cyc  = cyc;
            end
            if (abort_at >= 0 && rk_valid && rk_index == abort_at[3:0]) begin
                abort    = 1'b1;
                rk_ready = 1'b1;
                sbq.delete();
                @(negedge clk);
                abort = 1'b0;
                check("abort_idle", {busy, rk_valid}, 2'b00);
                return;
            end
            rk_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
            if (rk_valid && rk_ready) begin
                if (sbq.size() == 0) begin
                    check("extra_key", {rk_index, rk_data}, 0);
                    done = 1;
                end else begin
                    e = sbq.pop_front();
                    check("rk_xfer", {rk_index, rk_last, rk_data}, e);
                    got[rk_index] = rk_data;
                    n_xfer++;
                    if (e.last) done = 1;
                end
            end
            prev_stall = rk_valid && !rk_ready;
            snap       = {rk_index, rk_last, rk_data};
        end
        check("run_timeout", done, 1'b1);
        @(negedge clk);
        check("end_idle", {busy, rk_valid, rk_last}, 3'b000);
        check("queue_empty", sbq.size(), 0);
        if (nr < 0) check("nr", nr, 0);
    endtask

    initial begin
        logic [255:0] knew;
        bit           vseen;
        rst      = 1'b0;
        start    = 1'b0;
        start1   = 1'b0;
        key_len  = 2'd0;
        key_in   = '0;
        abort    = 1'b0;
        rk_ready = 1'b0;
        n_chk    = 0;
        n_fail   = 0;
        build_sbox();
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {busy, rk_valid, rk_data, rk_index, rk_last, err}, 0);
        rst = 1'b1;
        @(negedge clk);

        run_keys(K128, 0, 0, -1, 0);
        check("a1_count", n_xfer, 11);
        check("a1_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("a1_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a1_latency", last_cyc, 51);

        run_keys(K192, 1, 0, -1, 1);
        check("a2_count", n_xfer, 13);
        check("a2_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        run_keys(K256, 2, 0, -1, 0);
        check("a3_count", n_xfer, 15);
        check("a3_rk1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check("a3_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_keys({K128[255:128], 128'hdeadbeef_0badf00d_12345678_9abcdef0},
                 0, 1, -1, 0);
        check("rnd_count", n_xfer, 11);
        check("rnd_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        key_len = 2'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_rsvd", {err, busy, rk_valid}, 3'b100);
        @(negedge clk);
        check("err_rsvd_pulse", {err, busy, rk_valid}, 3'b000);
        key_len = 2'd2;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("err_unsup", {err1, busy1, rk_valid1}, 3'b100);
        @(negedge clk);
        check("err_unsup_pulse", {err1, busy1, rk_valid1}, 3'b000);

        run_keys(K128, 0, 0, 5, 0);
        knew = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        run_keys(knew, 0, 1, -1, 0);
        check("abort_new_count", n_xfer, 11);
        check("abort_new_rk0", got[0], knew[255:128]);

        key_in   = K256;
        key_len  = 2'd2;
        start    = 1'b1;
        rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_reset",
              {busy, rk_valid, rk_data, rk_index, rk_last, err}, 0);
        @(negedge clk);
        rst      = 1'b1;
        rk_ready = 1'b1;
        vseen    = 0;
        repeat (20) begin
            @(negedge clk);
            if (rk_valid || busy) vseen = 1;
        end
        check("no_keys_after_reset", vseen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Iterative, word-serial AES key expander supporting AES-128, AES-192 and AES-256 with a runtime key-length select. It sits between the key register file and the cipher round datapath. It emits one 128-bit round key per valid/ready transfer, in order rk[0]..rk[Nr]. It uses one shared 4-byte SubWord unit and generates Rcon internally. Back-pressure stalls expansion without loss.

Parameters:
SBOX_REG, 1, 1 = SubWord S-box lookup is registered and adds one cycle per SubWord word; 0 = combinational lookup.
KEY_SUPPORT, 3'b111, bitmask of enabled key lengths: bit0 = 128, bit1 = 192, bit2 = 256.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; samples key_in and key_len when idle
key_len  in  2  0 = 128, 1 = 192, 2 = 256, 3 = reserved
key_in  in  256  key in FIPS byte order; key_in[255:248] is byte 0; 128/192-bit keys are left-aligned, and unused low bits are ignored
abort  in  1  synchronous cancel; returns the block to IDLE
busy  out  1  high from the accepted start until the last round key is accepted
rk_valid  out  1  rk_data is valid
rk_ready  in  1  consumer accepts the key when rk_valid and rk_ready are both high
rk_data  out  128  round key; [127:96] = w[4r], [31:0] = w[4r+3]
rk_index  out  4  round number r, 0..Nr
rk_last  out  1  high with rk_valid when r == Nr
err  out  1  one-cycle pulse when start arrives with an unsupported or reserved key_len

Behaviour:
- Reset (rst = 0): state IDLE; all outputs 0 (busy, rk_valid, rk_data, rk_index, rk_last, err); all internal registers 0.
- Key-length constants:
  - Nk = 4/6/8 and Nr = 10/12/14.
  - Total words = 4*(Nr+1) = 44/52/60.
- Start in IDLE:
  - start with an unsupported key_len: err pulses the next cycle and the block stays IDLE.
  - start with a supported key_len: on the next edge, load w[0..Nk-1] into an 8-word window, set word counter i = Nk, set Rcon = 0x01 and set busy.
  - start while busy: ignored, no err.
- State machine: IDLE, GEN, SUB (present only if SBOX_REG = 1), HOLD.
- GEN computes w[i] = w[i-Nk] ^ t, where:
  - t = SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0} when i mod Nk == 0; Rcon then advances by xtime (0x80 -> 0x1B).
  - t = SubWord(w[i-1]) when Nk == 8 and i mod Nk == 4.
  - t = w[i-1] otherwise.
- Cycle cost per word:
  - Words needing SubWord cost 1+SBOX_REG cycles; the path is GEN -> SUB -> GEN.
  - All other words cost 1 cycle.
- Output grouping:
  - Words are collected 4 at a time into an output staging register.
  - Loaded key words count toward the groups: rk[0] = w[0..3]; for AES-192, rk[1] = w[4], w[5] (key) plus w[6], w[7] (generated).
  - rk[0] is presented the cycle after the start is accepted.
- Back-pressure:
  - When a group of 4 words completes while rk_valid = 1 and rk_ready = 0, the state moves to HOLD and no words are generated.
  - HOLD exits on the acceptance edge: staging moves to the output, rk_index increments, and GEN resumes.
- rk_data, rk_index and rk_last stay stable while rk_valid = 1 and rk_ready = 0.
- Termination:
  - Acceptance of rk[Nr] clears rk_valid and busy the next cycle and returns to IDLE.
  - A start in that same cycle is ignored; start is accepted only in IDLE.
- abort:
  - Has priority over start and over a transfer in the same cycle.
  - Next cycle: IDLE, busy = 0, rk_valid = 0; the window is not cleared.
- Reset mid-expansion: immediate return to the reset values; no partial keys are presented afterwards.
- Throughput: with rk_ready tied high and SBOX_REG = 1, AES-128 presents rk[10] exactly 51 cycles after start. That is 1 load cycle, 40 words and 10 SubWord stalls.

Test Plan:
- FIPS-197 A.1 AES-128: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready = 1 -> rk[1] = a0fafe17 88542cb1 23a33939 2a6c7605; rk[10] = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_last = 1; 11 transfers; rk[10] 51 cycles after start.
- FIPS-197 A.2 AES-192: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> 13 transfers; rk[12] = e98ba06f 448c773c 8ecc7204 01002202.
- FIPS-197 A.3 AES-256: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> 15 transfers; rk[14] = fe4890d1 e6188d0b 046df344 706c631e; rk[1] = 1f352c07 3b6108d7 2d9810a3 0914dff4.
- Random rk_ready (about 30% duty) on the AES-128 vector -> same 11 keys in order; rk_data, rk_index and rk_last stable while stalled; no drops or duplicates.
- key_len = 3, then key_len = 2 with KEY_SUPPORT = 3'b001 -> err pulses once each; busy and rk_valid stay 0.
- abort at rk_index = 5, then an immediate new AES-128 start -> rk[0] equals the new key and all 11 keys are correct; assert rst low mid-run -> all outputs 0 asynchronously.
